// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states, counter width.
// Imported by the bus arbiter and its timeout timer.
// Pure declarations, no logic.
package cpu_types_pkg;

  // Status reported by the RAM model/controller each cycle
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Bus arbiter FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISERV  = 3'd1,
    DSERV  = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } arb_state_t;

  // Width of the per-access cycle counter (TIMEOUT must fit in it)
  localparam int ARB_CNT_W = 8;

  // True while a requester owns the RAM
  function automatic logic arb_in_service(input arb_state_t s);
    return (s == ISERV) || (s == DSERV);
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Per-access cycle counter for the bus arbiter; expired flags the last allowed cycle.
// Latency: expired is combinational from the count, count updates each clock.
// No backpressure: clear has priority over enable, count saturates.
module arb_timer
  import cpu_types_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [ARB_CNT_W-1:0] CNT_MAX = {ARB_CNT_W{1'b1}};
  localparam logic [31:0]          LIMIT_U = 32'(LIMIT);

  logic [ARB_CNT_W-1:0] r_cnt;
  logic [31:0]          w_cnt_plus1;

  // Count service cycles since the last grant; saturate rather than wrap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The current cycle is the LIMIT-th one: if it does not complete, give up
  always_comb begin
    w_cnt_plus1 = 32'(r_cnt) + 32'd1;
    expired     = (w_cnt_plus1 >= LIMIT_U);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one RAM port between instruction and data requesters (round-robin on conflict).
// Latency: RAM path is combinational; grant takes one edge from IDLE, completion is same-cycle on ACCESS.
// Backpressure: requesters hold until their wait drops; halt blocks new grants, faults are terminal.
module bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction requester
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data requester
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  // control
  input  logic        halt,
  output logic        drained,
  output logic        err
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last_d;     // 1: data was served last, 0: instruction
  logic       w_dreq;
  logic       w_grant;
  logic       w_expired;

  // Timeout counter restarts on each grant and runs while a service is active
  arb_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (w_grant),
    .enable  (arb_in_service(r_state)),
    .expired (w_expired)
  );

  // State and round-robin pointer; pointer moves only when a service is granted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last_d <= (w_next == DSERV);
      end
    end
  end

  // Next-state selection and combinational RAM/requester muxing
  always_comb begin
    w_next   = r_state;
    w_dreq   = dREN | dWEN;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (r_state)
      IDLE: begin
        if (halt) begin
          w_next = HALTED;
        end else if (w_dreq && iREN) begin
          w_next = r_last_d ? ISERV : DSERV;
        end else if (w_dreq) begin
          w_next = DSERV;
        end else if (iREN) begin
          w_next = ISERV;
        end
      end

      ISERV: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
          if (halt)        w_next = HALTED;
          else if (w_dreq) w_next = DSERV;
          else             w_next = IDLE;
        end else if ((ramstate == ERROR) || w_expired) begin
          w_next = FAULT;
        end
      end

      DSERV: begin
        // a write wins when both enables are set
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ramstate == ACCESS) begin
          dwait = 1'b0;
          dload = ramload;
          if (halt)      w_next = HALTED;
          else if (iREN) w_next = ISERV;
          else           w_next = IDLE;
        end else if ((ramstate == ERROR) || w_expired) begin
          w_next = FAULT;
        end
      end

      HALTED:  w_next = HALTED;
      FAULT:   w_next = FAULT;
      default: w_next = FAULT;
    endcase

    // a grant is any entry into a service state, including the direct I<->D handover
    w_grant = arb_in_service(w_next) && (w_next != r_state);
  end

  // Status flags decode straight from the registered state
  always_comb begin
    drained = (r_state == HALTED);
    err     = (r_state == FAULT);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one cycle-stepped script, every output checked against hand values.
module tb_bus_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        halt;
  logic        drained;
  logic        err;

  int n_checks;
  int n_fail;

  bus_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .halt     (halt),
    .drained  (drained),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs set afterwards apply to the new cycle
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE; halt = 1'b0;

    // ---- reset values
    #3;
    chk("rst_iwait",   32'(iwait),   32'd1);
    chk("rst_dwait",   32'(dwait),   32'd1);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    chk("rst_ramren",  32'(ramREN),  32'd0);
    chk("rst_ramwen",  32'(ramWEN),  32'd0);
    tick(); tick();
    RST = 1'b0;

    // ---- S1: fetch, ACCESS on the 3rd service cycle
    iREN = 1'b1; iaddr = 32'h40; #1;
    chk("s1_idle_ramren", 32'(ramREN), 32'd0);
    tick(); ramstate = BUSY; #1;
    chk("s1_c1_ramren", 32'(ramREN), 32'd1);
    chk("s1_c1_addr",   ramaddr,     32'h40);
    chk("s1_c1_iwait",  32'(iwait),  32'd1);
    chk("s1_c1_iload",  iload,       32'h0);
    tick(); #1;
    chk("s1_c2_iwait",  32'(iwait),  32'd1);
    tick(); ramstate = ACCESS; ramload = 32'h8C220004; #1;
    chk("s1_c3_iwait",  32'(iwait),  32'd0);
    chk("s1_c3_iload",  iload,       32'h8C220004);
    chk("s1_c3_dwait",  32'(dwait),  32'd1);
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    chk("s1_idle_after", 32'(ramREN), 32'd0);
    chk("s1_iwait_after", 32'(iwait), 32'd1);
    chk("s1_iload_after", iload,      32'h0);

    // ---- S3: data write, write wins over read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY; #1;
    chk("s3_idle_ramwen", 32'(ramWEN), 32'd0);
    tick(); #1;
    chk("s3_c1_ramwen",  32'(ramWEN), 32'd1);
    chk("s3_c1_ramren",  32'(ramREN), 32'd0);
    chk("s3_c1_store",   ramstore,    32'hDEADBEEF);
    chk("s3_c1_addr",    ramaddr,     32'h100);
    chk("s3_c1_dwait",   32'(dwait),  32'd1);
    ramstate = ACCESS; ramload = 32'h12345678; #1;
    chk("s3_c2_dwait",   32'(dwait),  32'd0);
    chk("s3_c2_dload",   dload,       32'h12345678);
    chk("s3_c2_ramwen",  32'(ramWEN), 32'd1);
    tick(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
    chk("s3_idle_ramwen2", 32'(ramWEN), 32'd0);
    chk("s3_idle_store",   ramstore,    32'h0);
    chk("s3_idle_dload",   dload,       32'h0);

    // ---- S2: both requests from reset, data first, direct handover, round-robin
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h200; ramstate = BUSY; #1;
    chk("s2_rst_dwait", 32'(dwait), 32'd1);
    tick(); RST = 1'b0; #1;
    chk("s2_idle", 32'(ramREN), 32'd0);
    tick(); #1;
    chk("s2_first_addr",   ramaddr,     32'h200);
    chk("s2_first_ramren", 32'(ramREN), 32'd1);
    chk("s2_first_ramwen", 32'(ramWEN), 32'd0);
    ramstate = ACCESS; ramload = 32'hAAAA0001; #1;
    chk("s2_d_dwait", 32'(dwait), 32'd0);
    chk("s2_d_dload", dload,      32'hAAAA0001);
    chk("s2_d_iwait", 32'(iwait), 32'd1);
    tick(); dREN = 1'b0; ramload = 32'hBBBB0002; #1;
    chk("s2_direct_iserv", ramaddr,    32'h40);
    chk("s2_i_iwait",      32'(iwait), 32'd0);
    chk("s2_i_iload",      iload,      32'hBBBB0002);
    tick(); dREN = 1'b1; ramstate = BUSY; #1;
    chk("s2_gap_idle", 32'(ramREN), 32'd0);
    tick(); #1;
    chk("s2_rr_data", ramaddr, 32'h200);
    ramstate = ACCESS;
    tick(); dREN = 1'b0; #1;
    chk("s2_rr_then_i", ramaddr,    32'h40);
    chk("s2_rr_i_done", 32'(iwait), 32'd0);
    tick(); iREN = 1'b0; dREN = 1'b1; ramstate = BUSY; #1;
    chk("s2_idle2", 32'(ramREN), 32'd0);
    tick(); ramstate = ACCESS; #1;
    chk("s2_donly_addr", ramaddr, 32'h200);
    tick(); iREN = 1'b1; ramstate = BUSY; #1;
    chk("s2_idle3", 32'(ramREN), 32'd0);
    tick(); #1;
    chk("s2_rr_instr", ramaddr, 32'h40);
    ramstate = ACCESS;
    tick(); iREN = 1'b0; #1;
    chk("s2_rr_then_d", ramaddr, 32'h200);
    tick(); dREN = 1'b0; ramstate = FREE; #1;
    chk("s2_end_idle", 32'(ramREN), 32'd0);

    // ---- S5: halt during data service with instruction pending
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    tick(); iREN = 1'b1; halt = 1'b1; #1;
    chk("s5_no_preempt", ramaddr,    32'h300);
    chk("s5_c1_dwait",   32'(dwait), 32'd1);
    tick(); #1;
    chk("s5_c2_addr", ramaddr, 32'h300);
    ramstate = ACCESS; #1;
    chk("s5_done_dwait", 32'(dwait), 32'd0);
    tick(); dREN = 1'b0; ramstate = FREE; #1;
    chk("s5_drained", 32'(drained), 32'd1);
    chk("s5_no_grant", 32'(ramREN), 32'd0);
    chk("s5_iwait",   32'(iwait),   32'd1);
    halt = 1'b0;
    tick(); #1;
    chk("s5_stay_drained", 32'(drained), 32'd1);
    chk("s5_stay_ramren",  32'(ramREN),  32'd0);

    // ---- S6: reset mid-fetch
    RST = 1'b1; iREN = 1'b0; #1;
    chk("s6_rst_drained", 32'(drained), 32'd0);
    tick(); RST = 1'b0; iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY; #1;
    tick(); #1;
    chk("s6_iserv", 32'(ramREN), 32'd1);
    RST = 1'b1; ramstate = ACCESS; ramload = 32'h55; #1;
    chk("s6_rst_ramren", 32'(ramREN), 32'd0);
    chk("s6_rst_addr",   ramaddr,     32'h0);
    chk("s6_rst_iwait",  32'(iwait),  32'd1);
    chk("s6_rst_iload",  iload,       32'h0);
    tick(); RST = 1'b0; ramstate = BUSY; #1;
    chk("s6_idle", 32'(ramREN), 32'd0);
    tick(); #1;
    chk("s6_regrant_ren",  32'(ramREN), 32'd1);
    chk("s6_regrant_addr", ramaddr,     32'h44);
    ramstate = ACCESS;
    tick(); iREN = 1'b0; ramstate = FREE; #1;

    // ---- S4: timeout with TIMEOUT=4, then ERROR on first cycle
    iREN = 1'b1; iaddr = 32'h48; ramstate = BUSY;
    tick(); tick(); tick(); tick(); #1;
    chk("s4_c4_ramren", 32'(ramREN), 32'd1);
    chk("s4_c4_err",    32'(err),    32'd0);
    tick(); #1;
    chk("s4_fault_err",    32'(err),    32'd1);
    chk("s4_fault_ramren", 32'(ramREN), 32'd0);
    chk("s4_fault_iwait",  32'(iwait),  32'd1);
    chk("s4_fault_dwait",  32'(dwait),  32'd1);
    ramstate = ACCESS; #1;
    chk("s4_fault_no_done", 32'(iwait), 32'd1);
    tick(); #1;
    chk("s4_fault_sticky", 32'(err), 32'd1);
    RST = 1'b1; #1;
    chk("s4_rst_err", 32'(err), 32'd0);
    tick(); RST = 1'b0; iREN = 1'b0; dREN = 1'b1; daddr = 32'h500; ramstate = FREE; #1;
    tick(); ramstate = ERROR; #1;
    chk("s4e_c1_err",    32'(err),    32'd0);
    chk("s4e_c1_ramren", 32'(ramREN), 32'd1);
    tick(); #1;
    chk("s4e_fault_err",    32'(err),    32'd1);
    chk("s4e_fault_ramren", 32'(ramREN), 32'd0);
    chk("s4e_fault_dwait",  32'(dwait),  32'd1);
    chk("s4e_fault_addr",   ramaddr,     32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
